neuron_buffer_controller: RTL and testbench

Sequencing controller for the two ping-pong neuron buffers (N1, N2). It drives the buffer-select, read-address and write-address inputs of the neuron buffer swapper. Per layer it streams the read buffer to the convolution unit under a ready handshake and places pool-unit results into the write buffer. It swaps the buffer roles at layer end.

---
 rtl/neuron_buffer_controller_pkg.sv | 11 +
 rtl/nbc_row_counter.sv | 46 ++++
 rtl/neuron_buffer_controller.sv | 125 ++++++++++++
 tb/tb_neuron_buffer_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/neuron_buffer_controller_pkg.sv
// Shared constants for the neuron ping-pong buffer controller: FSM encoding and default address width.
package neuron_buffer_controller_pkg;

    localparam int unsigned NBC_A_DEFAULT = 7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_SWAP  = 2'd3;

endpackage

// File: rtl/nbc_row_counter.sv
// Row address/remaining-count pair for one side (read or write) of a neuron buffer layer.
module nbc_row_counter #(
    parameter int unsigned A  = 7,
    parameter int unsigned CW = A + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic [CW-1:0] count,
    input  logic          step,
    output logic [A-1:0]  address,
    output logic [CW-1:0] remaining,
    output logic          zero
);

    logic [A-1:0]  addr_q, addr_d;
    logic [CW-1:0] rem_q, rem_d;

    // Load restarts the address at row 0; a full 2^A count wraps it back to 0 at the end.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load) begin
            addr_d = '0;
            rem_d  = count;
        end else if (step) begin
            addr_d = addr_q + A'(1);
            rem_d  = rem_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign address   = addr_q;
    assign remaining = rem_q;
    assign zero      = (rem_q == '0);

endmodule

// File: rtl/neuron_buffer_controller.sv
// Ping-pong neuron buffer sequencer: streams the read buffer to conv, fills the write buffer from pool, swaps roles per layer.
// Optional sticky overflowErr port and logic enabled by defining NBC_OVERFLOW_CHECK_EN.
module neuron_buffer_controller
    import neuron_buffer_controller_pkg::*;
#(
    parameter int unsigned A  = NBC_A_DEFAULT,
    parameter int unsigned CW = A + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          layerStart,
    input  logic [CW-1:0] readRowCount,
    input  logic [CW-1:0] writeRowCount,
    input  logic          readReady,
    input  logic          poolValid,
    output logic          readBufferSelect,
    output logic [A-1:0]  readBuffAddress,
    output logic [A-1:0]  writeBuffAddress,
    output logic          readEnable,
    output logic          readDataValid,
    output logic          writeEnable,
    output logic          busy,
    output logic          layerDone
`ifdef NBC_OVERFLOW_CHECK_EN
    ,
    output logic          overflowErr
`endif
);

    logic [1:0]    state_q, state_d;
    logic          rd_sel_q, rd_sel_d;
    logic          rdv_q, rdv_d;
    logic          load_c;
    logic          read_en_c, write_en_c;
    logic [CW-1:0] rd_rem, wr_rem;
    logic          rd_zero, wr_zero;

    nbc_row_counter #(.A(A), .CW(CW)) u_rd_cnt (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load_c),
        .count     (readRowCount),
        .step      (read_en_c),
        .address   (readBuffAddress),
        .remaining (rd_rem),
        .zero      (rd_zero)
    );

    nbc_row_counter #(.A(A), .CW(CW)) u_wr_cnt (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load_c),
        .count     (writeRowCount),
        .step      (write_en_c),
        .address   (writeBuffAddress),
        .remaining (wr_rem),
        .zero      (wr_zero)
    );

    // Next-state and handshake decode; read and write sides advance independently.
    always_comb begin
        state_d    = state_q;
        rd_sel_d   = rd_sel_q;
        load_c     = 1'b0;
        read_en_c  = (state_q == ST_RUN) && readReady && (rd_rem != '0);
        write_en_c = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && poolValid && (wr_rem != '0);
        rdv_d      = read_en_c;
        case (state_q)
            ST_IDLE: begin
                if (layerStart) begin
                    load_c  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rd_zero) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Wait for the last read's data to leave the swapper before flipping buffers.
                if (wr_zero && !rdv_q) state_d = ST_SWAP;
            end
            ST_SWAP: begin
                rd_sel_d = ~rd_sel_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            rd_sel_q <= 1'b0;
            rdv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_sel_q <= rd_sel_d;
            rdv_q    <= rdv_d;
        end
    end

`ifdef NBC_OVERFLOW_CHECK_EN
    logic ovf_q, ovf_d;

    // Pool row arriving with nowhere to go; sticky until reset.
    always_comb begin
        ovf_d = ovf_q | (poolValid && (wr_zero || (state_q == ST_IDLE)));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ovf_q <= 1'b0;
        else         ovf_q <= ovf_d;
    end

    assign overflowErr = ovf_q;
`endif

    assign readBufferSelect = rd_sel_q;
    assign readEnable       = read_en_c;
    assign writeEnable      = write_en_c;
    assign readDataValid    = rdv_q;
    assign busy             = (state_q != ST_IDLE);
    assign layerDone        = (state_q == ST_SWAP);

endmodule

// File: tb/tb_neuron_buffer_controller.sv
// Scoreboard bench for neuron_buffer_controller: directed layers, expected addresses queued, monitor compares.
module tb_neuron_buffer_controller;

    localparam int unsigned A  = 7;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          layerStart = 1'b0;
    logic [CW-1:0] readRowCount = '0;
    logic [CW-1:0] writeRowCount = '0;
    logic          readReady = 1'b0;
    logic          poolValid = 1'b0;
    logic          readBufferSelect;
    logic [A-1:0]  readBuffAddress;
    logic [A-1:0]  writeBuffAddress;
    logic          readEnable;
    logic          readDataValid;
    logic          writeEnable;
    logic          busy;
    logic          layerDone;
`ifdef NBC_OVERFLOW_CHECK_EN
    logic          overflowErr;
`endif

    neuron_buffer_controller #(.A(A), .CW(CW)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .layerStart       (layerStart),
        .readRowCount     (readRowCount),
        .writeRowCount    (writeRowCount),
        .readReady        (readReady),
        .poolValid        (poolValid),
        .readBufferSelect (readBufferSelect),
        .readBuffAddress  (readBuffAddress),
        .writeBuffAddress (writeBuffAddress),
        .readEnable       (readEnable),
        .readDataValid    (readDataValid),
        .writeEnable      (writeEnable),
        .busy             (busy),
        .layerDone        (layerDone)
`ifdef NBC_OVERFLOW_CHECK_EN
        ,
        .overflowErr      (overflowErr)
`endif
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   rd_q[$];
    int   wr_q[$];
    int   done_q[$];
    int   done_cnt = 0;
    logic prev_re  = 1'b0;
    logic sel_model = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops an expectation whenever the DUT presents a read, write or layer completion.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_re = 1'b0;
        end else begin
            if (readDataValid || prev_re) check("rdv_trails_re", int'(readDataValid), int'(prev_re));
            prev_re = readEnable;
            if (readEnable) begin
                if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_addr", int'(readBuffAddress), rd_q.pop_front());
            end
            if (writeEnable) begin
                if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
                else check("wr_addr", int'(writeBuffAddress), wr_q.pop_front());
            end
            if (layerDone) begin
                check("done_rd_left", rd_q.size(), 0);
                check("done_wr_left", wr_q.size(), 0);
                if (done_q.size() == 0) check("done_unexpected", 1, 0);
                else check("done_sel", int'(readBufferSelect), done_q.pop_front());
                done_cnt++;
            end
        end
    end

    // Runs one layer; abort_at>=0 asserts reset at that cycle instead of completing.
    task automatic do_layer(input int rc, input int wc, input int rr_len, input logic [31:0] rr,
                            input int pv_delay, input int ign_k, input int abort_at,
                            output int busy_cycles);
        int start;
        int k;
        for (int i = 0; i < rc; i++) rd_q.push_back(i % 128);
        for (int i = 0; i < wc; i++) wr_q.push_back(i % 128);
        if (abort_at < 0) done_q.push_back(int'(sel_model));
        start = done_cnt;
        layerStart    = 1'b1;
        readRowCount  = CW'(rc);
        writeRowCount = CW'(wc);
        @(posedge clk); #1;
        layerStart = 1'b0;
        check("busy_after_start", int'(busy), 1);
        busy_cycles = 0;
        k = 0;
        while (done_cnt == start && k < 400) begin
            if (abort_at >= 0 && k == abort_at) begin
                resetn = 1'b0;
                break;
            end
            busy_cycles += int'(busy);
            readReady  = (k < rr_len) ? rr[k[4:0]] : 1'b1;
            poolValid  = (k >= pv_delay);
            layerStart = (k == ign_k);
            if (k == ign_k) readRowCount = CW'(1);
            @(posedge clk); #1;
            k++;
        end
        readReady  = 1'b0;
        poolValid  = 1'b0;
        layerStart = 1'b0;
        if (abort_at >= 0) begin
            rd_q.delete();
            wr_q.delete();
        end else begin
            check("layer_timeout", int'(k < 400), 1);
            sel_model = ~sel_model;
            check("sel_toggled", int'(readBufferSelect), int'(sel_model));
            check("idle_after", int'(busy), 0);
            check("rd_addr_end", int'(readBuffAddress), rc % 128);
            check("wr_addr_end", int'(writeBuffAddress), wc % 128);
            check("rd_q_empty", rd_q.size(), 0);
            check("wr_q_empty", wr_q.size(), 0);
        end
    endtask

    initial begin
        int bc;
        #2;
        check("rst_sel", int'(readBufferSelect), 0);
        check("rst_rd_addr", int'(readBuffAddress), 0);
        check("rst_wr_addr", int'(writeBuffAddress), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(layerDone), 0);
        check("rst_rdv", int'(readDataValid), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Basic 4x4 layer, then an identical one swapping back.
        do_layer(4, 4, 0, 32'h0, 0, -1, -1, bc);
        do_layer(4, 4, 0, 32'h0, 0, -1, -1, bc);
        // Toggled readReady 1,0,1,0,1; a stray layerStart mid-layer must be ignored.
        do_layer(3, 2, 5, 32'b10101, 0, 1, -1, bc);
        // Late pool rows keep the layer in DRAIN until the 5th write.
        do_layer(2, 5, 0, 32'h0, 10, -1, -1, bc);
        // Full 2^A rows on both sides: addresses wrap back to 0.
        do_layer(128, 128, 0, 32'h0, 0, -1, -1, bc);

        // Reset in the middle of RUN aborts the layer with no layerDone.
        check("sel_before_abort", int'(readBufferSelect), 1);
        do_layer(8, 8, 0, 32'h0, 0, -1, 3, bc);
        #1;
        check("abort_sel", int'(readBufferSelect), 0);
        check("abort_rd_addr", int'(readBuffAddress), 0);
        check("abort_wr_addr", int'(writeBuffAddress), 0);
        check("abort_re", int'(readEnable), 0);
        check("abort_we", int'(writeEnable), 0);
        check("abort_rdv", int'(readDataValid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(layerDone), 0);
        sel_model = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
`ifdef NBC_OVERFLOW_CHECK_EN
        check("ovf_after_reset", int'(overflowErr), 0);
        poolValid = 1'b1;
        @(posedge clk); #1;
        poolValid = 1'b0;
        check("ovf_idle_pool", int'(overflowErr), 1);
`else
        poolValid = 1'b1;
        @(posedge clk); #1;
        poolValid = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        check("idle_no_layer", int'(busy), 0);

        // Minimum layer: busy exactly RUN, DRAIN, SWAP.
        do_layer(0, 0, 0, 32'h0, 0, -1, -1, bc);
        check("min_busy_cycles", bc, 3);
        check("done_count", done_cnt, 6);

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
